option_fifo_feeder: RTL and testbench
=====================================

// Module: option_fifo_feeder
// PURPOSE
//  Circular option queue that feeds the line solver. It stores line-header words (line index) and option words (candidate line bit patterns).
//  It streams them to the solver over a valid/ready port. Headers are recirculated automatically; option words are recirculated only when the solver's keep decision says so.
//  It flags convergence after a full rotation with no option removed.
// PARAMETERS
//  SIZE   3   puzzle side; option width in bits; lines are indexed 0..2*SIZE-1 (rows, then columns)
//  DEPTH  64  queue capacity in words; power of two
//  Derived: W = SIZE+1 (bit W-1 = tag: 1 header, 0 option); AW = $clog2(DEPTH)
// PORTS
//  clk        in   1     clock
//  rst        in   1     reset, synchronous, active-high
//  load_valid in   1     initial-fill word strobe (honoured only in LOAD)
//  load_tag   in   1     1 = header, 0 = option
//  load_data  in   SIZE  line index (header; zero-extended) or option bits
//  load_done  in   1     fill complete; pulse
//  out_valid  out  1     out_tag/out_data valid to solver
//  out_ready  in   1     solver accepts word
//  out_tag    out  1     tag of head word
//  out_data   out  SIZE  payload of head word
//  dec_valid  in   1     keep/drop decision for last popped option; pulse
//  dec_keep   in   1     1 = re-push option at tail, 0 = discard
//  count      out  AW+1  words currently stored
//  full       out  1     count == DEPTH
//  overflow   out  1     sticky; load_valid while full
//  converged  out  1     level; high in DONE
// BEHAVIOUR
//  Reset: all outputs 0, rd/wr pointers 0, count 0, state LOAD; reset mid-RUN discards all contents.
//  Storage: DEPTH x W array, single write port, wrap-around pointers; one write max per cycle.
//  States: LOAD -> RUN on load_done with count>0; LOAD -> DONE on load_done with count==0; RUN -> DONE on convergence; DONE holds until rst.
//  LOAD: load_valid && !full writes {load_tag,load_data} at tail; load_valid && full sets overflow, word dropped; out_valid=0.
//  RUN: out_valid=1 when count>0 and not WAIT_DEC; out_tag/out_data are the registered head word, no bubble between back-to-back pops.
//  Pop = out_valid && out_ready. Header pop: same cycle, the header is re-written at tail; count is unchanged.
//  Option pop: count-1 and enter WAIT_DEC; out_valid=0 until dec_valid.
//  dec_valid && dec_keep: the option is written at tail; count+1. dec_valid && !dec_keep: nothing is written; drop_seen<=1.
//    WAIT_DEC exits on the dec_valid cycle; the next pop is allowed the following cycle.
//  dec_valid outside WAIT_DEC is ignored. load_valid in RUN or DONE is ignored.
//  Rotation: on entering RUN, rot_left<=count and drop_seen<=0. Each pop decrements rot_left.
//    When rot_left reaches 0 after a decision/recirc completes: if !drop_seen -> DONE, else rot_left<=count and drop_seen<=0.
//  Convergence is also declared when count reaches 0 or when only header words remain.
//  DONE: out_valid=0, converged=1, contents frozen.
//  Pointer wrap: rd/wr advance modulo DEPTH; header recirculation while full is legal because pop and push occur in the same cycle.
// TESTING
//  Fill H0,A,B,H1,C; load_done; hold ready=1, keep all -> order H0,A,B,H1,C,H0..., count stays 5, converged after 5 pops + decisions.
//  Same fill, drop B on 1st rotation, keep all on 2nd -> count 4; converged=1 only at end of 2nd rotation.
//  Option popped, dec_valid delayed 3 cycles -> out_valid=0 for those 3 cycles, next word presented cycle after dec.
//  Fill DEPTH words + 1 extra -> full=1, overflow=1, count=DEPTH; headers recirculate correctly across pointer wrap.
//  load_done with empty queue -> converged=1 next cycle, out_valid=0.
//  rst asserted mid-RUN with out_ready=1 -> next cycle count=0, out_valid=0, state LOAD, overflow cleared.

Source files
------------

// File: rtl/option_fifo_feeder.sv
// option_fifo_feeder
//   Circular option queue feeding the line solver. The queue holds
//   line-header words (tag=1, payload = line index) and option words
//   (tag=0, payload = candidate bit pattern for that line). The words are
//   streamed to the solver in order. A header is written back at the tail
//   in the same cycle it is popped. A popped option is held until the
//   solver's keep/drop decision arrives, and is re-queued only if kept.
//   The block reports convergence once a full rotation of the queue has
//   completed without any option being dropped. It also converges when the
//   queue empties or holds only header words.
//
// Handshake (solver port): a word transfers on every rising clk edge where
//   out_valid && out_ready. out_valid never depends on out_ready, and
//   out_tag/out_data stay stable while out_valid is high and no transfer
//   has occurred. After an option transfers, out_valid stays low until the
//   dec_valid pulse. The next word may transfer in the cycle after that
//   pulse.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   load_valid/tag/data  initial fill stream (accepted only in LOAD)
//   load_done            end-of-fill pulse
//   out_valid/ready      solver stream handshake
//   out_tag, out_data    head word (zero when out_valid is low)
//   dec_valid, dec_keep  decision for the most recently popped option
//   count, full          occupancy
//   overflow             sticky: a load word arrived while full
//   converged            high once DONE is reached
//   state_dbg            current FSM state (0 LOAD, 1 RUN, 2 WAIT_DEC, 3 DONE)

module option_fifo_feeder #(
  parameter int SIZE  = 3,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic                       load_tag,
  input  logic [SIZE-1:0]            load_data,
  input  logic                       load_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_tag,
  output logic [SIZE-1:0]            out_data,
  input  logic                       dec_valid,
  input  logic                       dec_keep,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic                       converged,
  output logic [1:0]                 state_dbg
);

  localparam int W  = SIZE + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_DEC = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t state, state_next;

  // Storage and bookkeeping
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] opt_count;   // option words currently stored
  logic [CW-1:0] rot_left;    // pops remaining in the current rotation
  logic          drop_seen;   // an option was dropped during this rotation
  logic          overflow_q;
  logic [W-1:0]  held;        // option awaiting its keep/drop decision

  // Datapath controls
  logic [W-1:0]  head;
  logic          pop, hdr_pop, opt_pop;
  logic          dec_fire, keep_fire;
  logic          load_wr, load_ovf;
  logic          wr_en;
  logic [W-1:0]  wr_word;
  logic [CW-1:0] count_next, opt_count_next;
  logic          rot_eval, rot_zero, drop_eff;
  logic          conv_now, rot_reload;
  logic          full_i;

  assign head   = mem[rd_ptr];
  assign full_i = (count_q == CW'(DEPTH));

  // ---------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------
  always_comb begin
    pop       = out_valid && out_ready;
    hdr_pop   = pop && head[W-1];
    opt_pop   = pop && !head[W-1];
    dec_fire  = (state == ST_WAIT_DEC) && dec_valid;
    keep_fire = dec_fire && dec_keep;
    load_wr   = (state == ST_LOAD) && load_valid && !full_i;
    load_ovf  = (state == ST_LOAD) && load_valid && full_i;

    // Only one source can write in a given cycle: loads happen only in
    // LOAD, header recirculation only in RUN, kept options only in WAIT_DEC.
    wr_en   = load_wr || hdr_pop || keep_fire;
    wr_word = held;
    if (load_wr)      wr_word = {load_tag, load_data};
    else if (hdr_pop) wr_word = head;

    count_next = count_q + CW'(load_wr) + CW'(keep_fire) - CW'(opt_pop);
    opt_count_next = opt_count + CW'(load_wr && !load_tag) + CW'(keep_fire)
                     - CW'(opt_pop);

    // A rotation step is complete either at a header pop (the recirc is
    // same-cycle) or at the decision following an option pop. For a header
    // pop, the decrement happens in this same cycle, so "reaches zero"
    // means rot_left is 1 now.
    rot_eval = hdr_pop || dec_fire;
    rot_zero = hdr_pop ? (rot_left == CW'(1)) : (rot_left == '0);
    drop_eff = drop_seen || (dec_fire && !dec_keep);

    conv_now   = rot_eval && ((rot_zero && !drop_eff) ||
                              (count_next == '0) ||
                              (opt_count_next == '0));
    rot_reload = rot_eval && rot_zero && drop_eff && !conv_now;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: begin
        if (load_done) state_next = (count_next != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (opt_pop)                  state_next = ST_WAIT_DEC;
        else if (hdr_pop && conv_now) state_next = ST_DONE;
      end
      ST_WAIT_DEC: begin
        if (dec_fire) state_next = conv_now ? ST_DONE : ST_RUN;
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    out_valid = (state == ST_RUN) && (count_q != '0);
    out_tag   = 1'b0;
    out_data  = '0;
    if (out_valid) begin
      out_tag  = head[W-1];
      out_data = head[SIZE-1:0];
    end
    converged = (state == ST_DONE);
    state_dbg = state;
    count     = count_q;
    full      = full_i;
    overflow  = overflow_q;
  end

  // ---------------------------------------------------------------------
  // Storage array (contents need no reset: occupancy gates every read)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr] <= wr_word;
  end

  // ---------------------------------------------------------------------
  // Pointers, counters, rotation tracking
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      opt_count  <= '0;
      rot_left   <= '0;
      drop_seen  <= 1'b0;
      overflow_q <= 1'b0;
      held       <= '0;
    end else begin
      // Pointers wrap naturally: DEPTH is a power of two.
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count_q   <= count_next;
      opt_count <= opt_count_next;
      if (opt_pop)  held       <= head;
      if (load_ovf) overflow_q <= 1'b1;

      if ((state == ST_LOAD) && load_done) begin
        rot_left  <= count_next;
        drop_seen <= 1'b0;
      end else if (rot_reload) begin
        rot_left  <= count_next;
        drop_seen <= 1'b0;
      end else begin
        if (pop && (rot_left != '0)) rot_left <= rot_left - CW'(1);
        if (dec_fire && !dec_keep)   drop_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_option_fifo_feeder.sv
module tb_option_fifo_feeder;

  localparam int SIZE  = 3;
  localparam int DEPTH = 64;
  localparam int W     = SIZE + 1;
  localparam int AW    = $clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            load_valid = 1'b0;
  logic            load_tag   = 1'b0;
  logic [SIZE-1:0] load_data  = '0;
  logic            load_done  = 1'b0;
  logic            out_valid;
  logic            out_ready  = 1'b0;
  logic            out_tag;
  logic [SIZE-1:0] out_data;
  logic            dec_valid  = 1'b0;
  logic            dec_keep   = 1'b0;
  logic [AW:0]     count;
  logic            full;
  logic            overflow;
  logic            converged;
  logic [1:0]      state_dbg;

  option_fifo_feeder #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_tag   (load_tag),
    .load_data  (load_data),
    .load_done  (load_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .out_data   (out_data),
    .dec_valid  (dec_valid),
    .dec_keep   (dec_keep),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .converged  (converged),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: the queue contents the solver should see, in order.
  logic [W-1:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    load_valid = 1'b0;
    load_done  = 1'b0;
    dec_valid  = 1'b0;
    dec_keep   = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_word(input logic tag, input logic [SIZE-1:0] data);
    load_valid = 1'b1;
    load_tag   = tag;
    load_data  = data;
    if (exp_q.size() < DEPTH) exp_q.push_back({tag, data});
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic finish_load();
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
  endtask

  task automatic load_sample5();
    load_word(1'b1, 3'd0);    // H0
    load_word(1'b0, 3'b101);  // A
    load_word(1'b0, 3'b011);  // B
    load_word(1'b1, 3'd1);    // H1
    load_word(1'b0, 3'b110);  // C
  endtask

  // 64 words: headers everywhere except options at 31 and 63; plus one extra.
  task automatic load_big();
    for (int i = 0; i <= DEPTH; i++) begin
      logic [SIZE-1:0] d;
      d = SIZE'(i % 8);
      if (i == 31 || i == 63) load_word(1'b0, d);
      else                    load_word(1'b1, d);
    end
  endtask

  // Consume n words with out_ready held high. The option popped at index
  // drop_at is dropped; every other option is kept. Each decision is
  // delayed by dec_delay cycles. Convergence is expected exactly after the
  // last word.
  task automatic run_words(input int n, input int drop_at, input int dec_delay);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] exp_w;
      int wait_cnt;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL no_bubble[%0d]: out_valid=%b expected 1", i, out_valid);
        wait_cnt = 0;
        while (out_valid !== 1'b1 && wait_cnt < 20) begin
          @(negedge clk);
          wait_cnt++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL valid_timeout[%0d]: out_valid=%b expected 1", i, out_valid);
          return;
        end
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty[%0d]: got %b_%b expected nothing", i, out_tag, out_data);
        return;
      end
      exp_w = exp_q.pop_front();
      checks++;
      if ({out_tag, out_data} !== exp_w) begin
        errors++;
        $display("FAIL word[%0d]: got %b_%b expected %b_%b", i, out_tag, out_data,
                 exp_w[W-1], exp_w[SIZE-1:0]);
      end
      checks++;
      if (converged !== 1'b0) begin
        errors++;
        $display("FAIL early_converged[%0d]: converged=%b expected 0", i, converged);
      end
      @(negedge clk);  // pop happened at the posedge just passed
      if (exp_w[W-1]) begin
        exp_q.push_back(exp_w);
      end else begin
        for (int k = 0; k < dec_delay; k++) begin
          checks++;
          if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_dec_idle[%0d.%0d]: out_valid=%b expected 0", i, k, out_valid);
          end
          @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL wait_dec_idle[%0d]: out_valid=%b expected 0", i, out_valid);
        end
        dec_valid = 1'b1;
        dec_keep  = (i != drop_at);
        @(negedge clk);
        dec_valid = 1'b0;
        dec_keep  = 1'b0;
        if (i != drop_at) exp_q.push_back(exp_w);
      end
      checks++;
      if (count !== (AW+1)'(exp_q.size())) begin
        errors++;
        $display("FAIL count[%0d]: got %0d expected %0d", i, count, exp_q.size());
      end
      if (i == n - 1) begin
        checks++;
        if (converged !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL converge_end: converged=%b out_valid=%b expected 1/0", converged, out_valid);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== '0 || full !== 1'b0 || overflow !== 1'b0 || converged !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: count=%0d full=%b ovf=%b conv=%b expected 0/0/0/0",
               count, full, overflow, converged);
    end
    checks++;
    if (out_valid !== 1'b0 || out_tag !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_out: valid=%b tag=%b data=%b expected all 0", out_valid, out_tag, out_data);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
  endtask

  task automatic test_keep_all();
    do_reset();
    load_sample5();
    checks++;
    if (count !== 7'd5 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_count: count=%0d valid=%b expected 5/0", count, out_valid);
    end
    finish_load();
    run_words(5, -1, 0);
  endtask

  task automatic test_drop_rotation();
    do_reset();
    load_sample5();
    finish_load();
    // Pop index 2 is option B; the second rotation has 4 words.
    run_words(9, 2, 0);
    checks++;
    if (count !== 7'd4) begin
      errors++;
      $display("FAIL drop_final_count: got %0d expected 4", count);
    end
  endtask

  task automatic test_dec_delay();
    do_reset();
    load_word(1'b1, 3'd2);
    load_word(1'b0, 3'b010);
    finish_load();
    run_words(2, -1, 3);
  endtask

  task automatic test_full_wrap();
    do_reset();
    load_big();
    checks++;
    if (full !== 1'b1 || overflow !== 1'b1 || count !== 7'(DEPTH)) begin
      errors++;
      $display("FAIL full_load: full=%b ovf=%b count=%0d expected 1/1/%0d",
               full, overflow, count, DEPTH);
    end
    finish_load();
    // Rotation 1: 64 words, option 31 dropped; rotation 2: 63 words.
    run_words(127, 31, 0);
  endtask

  task automatic test_empty_done();
    do_reset();
    finish_load();
    checks++;
    if (converged !== 1'b1 || out_valid !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL empty_done: conv=%b valid=%b count=%0d expected 1/0/0",
               converged, out_valid, count);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_big();
    finish_load();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || overflow !== 1'b1 || count !== 7'(DEPTH)) begin
      errors++;
      $display("FAIL mid_run_pre: valid=%b ovf=%b count=%0d expected 1/1/%0d",
               out_valid, overflow, count, DEPTH);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || state_dbg !== 2'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: count=%0d valid=%b state=%0d ovf=%b expected 0/0/0/0",
               count, out_valid, state_dbg, overflow);
    end
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_keep_all();
    test_drop_rotation();
    test_dec_delay();
    test_full_wrap();
    test_empty_done();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
